// File: rtl/pci_pkg.sv
// Shared PCI definitions: command codes, completion status, initiator states,
// and the latched burst request.
package pci_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned CBE_W  = 4;

    localparam logic [CBE_W-1:0] MEM_READ  = 4'h6;
    localparam logic [CBE_W-1:0] MEM_WRITE = 4'h7;

    typedef enum logic [1:0] {
        STAT_OK     = 2'd0,
        STAT_DISC   = 2'd1,
        STAT_RETRY  = 2'd2,
        STAT_MABORT = 2'd3
    } pci_status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_LAST  = 3'd3,
        S_ABORT = 3'd4,
        S_TURN  = 3'd5
    } pci_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  phases;
    } pci_req_t;

    // A length field of zero encodes the maximum burst of 16 phases.
    function automatic logic [CNT_W-1:0] len_to_phases(input logic [LEN_W-1:0] len);
        return (len == '0) ? CNT_W'(16) : CNT_W'(len);
    endfunction

endpackage

// File: rtl/pci_devsel_timer.sv
// Counts data-phase clocks without DEVSEL#; flags master abort on the clock
// that would reach the timeout.
module pci_devsel_timer #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired_c) begin
            cnt_q <= cnt_q + TMR_W'(1);
        end
    end

    assign expired_c = enable && (cnt_q == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/pci_master_initiator.sv
// PCI bus initiator for single-address memory read/write bursts with
// completion status (OK, disconnect, retry, master abort).
module pci_master_initiator
    import pci_pkg::*;
#(
    parameter int unsigned DEVSEL_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req,
    input  logic              Cmd,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [LEN_W-1:0]  Len,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrNext,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        Status,
    output logic [CNT_W-1:0]  XferCnt,
    output logic              FrameN,
    output logic              IrdyN,
    output logic [CBE_W-1:0]  CbeN,
    output logic [DATA_W-1:0] AdOut,
    output logic              AdOe,
    input  logic [DATA_W-1:0] AdIn,
    input  logic              DevselN,
    input  logic              TrdyN,
    input  logic              StopN
);

    pci_state_e        state_q, state_d;
    pci_req_t          req_c;
    logic              wr_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              stop_seen_q, devsel_seen_q;
    logic              accept_c, in_data_c, xfer_c, stop_c;
    logic              tmr_clear_c, tmr_enable_c, expired_c;
    logic [CNT_W-1:0]  cnt_after_c, rem_after_c;

    logic              frame_d, irdy_d, ad_oe_d, done_d;
    logic [CBE_W-1:0]  cbe_d;
    logic [DATA_W-1:0] ad_out_d;
    pci_status_e       status_d;

    assign req_c       = '{write: Cmd, addr: Addr, phases: len_to_phases(Len)};
    assign accept_c    = (state_q == S_IDLE) && Req;
    assign in_data_c   = (state_q == S_DATA) || (state_q == S_LAST);
    // IRDY# is always asserted in DATA/LAST, so a transfer needs only the target side.
    assign xfer_c      = in_data_c && !DevselN && !TrdyN;
    assign stop_c      = in_data_c && !DevselN && !StopN;
    assign cnt_after_c = XferCnt + CNT_W'(xfer_c);
    assign rem_after_c = remaining_q - CNT_W'(xfer_c);

    assign tmr_clear_c  = (state_q == S_IDLE);
    assign tmr_enable_c = in_data_c && DevselN && !devsel_seen_q;

    pci_devsel_timer #(
        .TIMEOUT (DEVSEL_TIMEOUT)
    ) u_devsel_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tmr_clear_c),
        .enable    (tmr_enable_c),
        .expired_c (expired_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (Req) state_d = S_ADDR;
            S_ADDR:  state_d = (remaining_q == CNT_W'(1)) ? S_LAST : S_DATA;
            S_DATA: begin
                if (expired_c) begin
                    state_d = S_ABORT;
                end else if ((xfer_c && remaining_q == CNT_W'(2)) || stop_c) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                if (expired_c) begin
                    state_d = S_ABORT;
                end else if (!DevselN && (!TrdyN || !StopN)) begin
                    state_d = S_TURN;
                end
            end
            S_ABORT: state_d = S_TURN;
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode for the cycle being entered; registered below
    always_comb begin
        frame_d  = 1'b1;
        irdy_d   = 1'b1;
        cbe_d    = 4'hF;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        done_d   = 1'b0;
        status_d = pci_status_e'(Status);
        unique case (state_d)
            S_ADDR: begin
                frame_d  = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = req_c.addr;
                cbe_d    = req_c.write ? MEM_WRITE : MEM_READ;
            end
            S_DATA, S_LAST, S_ABORT: begin
                frame_d  = (state_d != S_DATA);
                irdy_d   = 1'b0;
                cbe_d    = 4'h0;
                ad_oe_d  = wr_q;
                ad_out_d = wr_q ? WrData : '0;
            end
            S_TURN: begin
                done_d = 1'b1;
                if (state_q == S_ABORT) begin
                    status_d = STAT_MABORT;
                end else if ((stop_seen_q || stop_c) && cnt_after_c == '0) begin
                    status_d = STAT_RETRY;
                end else if ((stop_seen_q || stop_c) && rem_after_c != '0) begin
                    status_d = STAT_DISC;
                end else begin
                    status_d = STAT_OK;
                end
            end
            default: ;
        endcase
    end

    // Registered bus and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FrameN <= 1'b1;
            IrdyN  <= 1'b1;
            CbeN   <= 4'hF;
            AdOe   <= 1'b0;
            AdOut  <= '0;
            Done   <= 1'b0;
            Status <= 2'd0;
            Busy   <= 1'b0;
        end else begin
            FrameN <= frame_d;
            IrdyN  <= irdy_d;
            CbeN   <= cbe_d;
            AdOe   <= ad_oe_d;
            AdOut  <= ad_out_d;
            Done   <= done_d;
            Status <= status_d;
            Busy   <= (state_d != S_IDLE);
        end
    end

    // Burst counters, target-response history and per-transfer pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q          <= 1'b0;
            remaining_q   <= '0;
            XferCnt       <= '0;
            stop_seen_q   <= 1'b0;
            devsel_seen_q <= 1'b0;
            RdData        <= '0;
            RdValid       <= 1'b0;
            WrNext        <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_q          <= req_c.write;
                remaining_q   <= req_c.phases;
                XferCnt       <= '0;
                stop_seen_q   <= 1'b0;
                devsel_seen_q <= 1'b0;
            end else begin
                if (xfer_c) begin
                    remaining_q <= rem_after_c;
                    XferCnt     <= cnt_after_c;
                end
                if (stop_c) stop_seen_q <= 1'b1;
                if (in_data_c && !DevselN) devsel_seen_q <= 1'b1;
            end
            RdValid <= xfer_c && !wr_q;
            WrNext  <= xfer_c && wr_q;
            if (xfer_c && !wr_q) RdData <= AdIn;
        end
    end

endmodule

// File: doc/pci_master_initiator.md
# pci_master_initiator

PCI initiator (bus master) for single-address, multi-data-phase memory read and write bursts. It is the counterpart to the slave-side read/write decode.

- A local client requests a burst with command, address and length.
- The block drives FRAME#/IRDY#/C/BE#/AD, tracks DEVSEL#/TRDY#/STOP# from the target, and streams the data.
- It reports completion status: normal, disconnect, retry or master abort.
- No arbitration: the bus is assumed already granted.

## Interface
- DEVSEL_TIMEOUT, 4: data-phase clocks with DevselN high before master abort.
- clk  in  1  system clock; everything samples on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Req  in  1  start burst; sampled only in IDLE
- Cmd  in  1  0 = memory read (C/BE 4'h6), 1 = memory write (4'h7)
- Addr  in  32  burst start address
- Len  in  4  data phases; 0 means 16
- WrData  in  32  write data; must be valid while Busy during a write
- WrNext  out  1  1-cycle pulse after each write transfer; client presents the next word on the following cycle
- RdData  out  32  registered read data
- RdValid  out  1  1-cycle pulse, RdData valid
- Busy  out  1  burst in progress
- Done  out  1  1-cycle completion pulse
- Status  out  2  0 OK, 1 DISC, 2 RETRY, 3 MABORT; valid with Done and held until next Done
- XferCnt  out  5  completed data transfers; valid with Done
- FrameN, IrdyN  out  1  PCI FRAME#, IRDY#
- CbeN  out  4  PCI C/BE#
- AdOut  out  32  AD drive value
- AdOe  out  1  AD output enable
- AdIn  in  32  AD sampled value
- DevselN, TrdyN, StopN  in  1  target responses

## Operation
- States: IDLE, ADDR, DATA, LAST, ABORT, TURN.
- **Transfer:** occurs at a clock edge with IrdyN=0, DevselN=0, TrdyN=0. It decrements the 5-bit remaining counter and increments XferCnt.
- **IDLE**
  - Outputs: all PCI outputs released.
  - Req=1 latches Cmd/Addr/Len, clears XferCnt, sets Busy, then goes to ADDR.
- **ADDR** (one cycle)
  - Outputs: FrameN=0, IrdyN=1, AdOe=1, AdOut=Addr, CbeN=command.
  - Next state: LAST if Len=1, else DATA.
- **DATA**
  - Outputs: FrameN=0, IrdyN=0, CbeN=4'h0.
  - Write: AdOe=1, AdOut=WrData. Read: AdOe=0.
  - If a transfer leaves remaining=1, go to LAST.
  - If StopN=0 with DevselN=0, go to LAST. A simultaneous TrdyN=0 still counts as a transfer.
- **LAST**
  - Outputs: FrameN=1, IrdyN=0; other outputs as in DATA.
  - Exits to TURN on the first edge with DevselN=0 and either TrdyN=0 or StopN=0. TrdyN=0 counts as a transfer.
- **Master abort:** a counter runs in DATA/LAST while DevselN=1 and freezes once DevselN has been seen low. When it reaches DEVSEL_TIMEOUT, go to ABORT.
- **ABORT** (one cycle): FrameN=1, IrdyN=0. Then go to TURN.
- **TURN** (one cycle)
  - Outputs: all PCI outputs released; Done=1.
  - Status selection, in priority order:
    - MABORT if entered from ABORT.
    - RETRY if STOP was seen and XferCnt=0.
    - DISC if STOP was seen and phases remain.
    - OK otherwise.
  - Clears Busy; returns to IDLE.
- **Per-transfer pulses:** a read transfer registers AdIn into RdData and pulses RdValid the next cycle. A write transfer pulses WrNext the next cycle and advances to the next WrData.
- **STOP in the final transfer:** StopN=0 on the final transfer that also has TrdyN=0 gives OK, not DISC.

## Timing
- **Reset values:** FrameN=1, IrdyN=1, CbeN=4'hF, AdOe=0, AdOut=0, RdData=0, RdValid=0, WrNext=0, Busy=0, Done=0, Status=0, XferCnt=0. State is IDLE.
- **Mid-burst reset** releases the bus immediately and asynchronously. No Done is issued.
- **Minimum burst length:** 1 + Len + 1 + 1 cycles from Req accept to Done, with zero wait states:
  - accept cycle → ADDR;
  - each data phase is one cycle;
  - TURN is one cycle.
- **Wait states:** each TrdyN=1 cycle extends the phase by one clock. IrdyN never deasserts mid-burst.
- **FrameN** never reasserts within a burst after going high.
- **Req** is ignored while Busy. A back-to-back Req is accepted in the IDLE cycle after TURN, so bursts are separated by one idle clock.

## Structure
- Shared package pci_pkg holds:
  - PCI command codes (MEM_READ 4'h6, MEM_WRITE 4'h7);
  - the Status encoding;
  - the state enumeration.
- The slave decode uses the same command constants.
- One natural sub-module: pci_devsel_timer, the DEVSEL timeout counter with clear/enable/expired.
- The FSM, counters and datapath stay in the top module.

## Test plan
- **Single write:** Len=1, Cmd=1, Addr=32'h1000, WrData=32'hCAFEF00D; DevselN/TrdyN low in the first data clock.
  - ADDR shows CbeN=4'h7 and AdOut=32'h1000.
  - LAST shows FrameN=1, IrdyN=0, AdOut=32'hCAFEF00D.
  - Then Done with Status=0, XferCnt=1, and WrNext once.
- **4-phase read with waits:** TrdyN high for 1 clock before each transfer; AdIn=1,2,3,4.
  - RdValid pulses 4 times with RdData 1,2,3,4.
  - FrameN goes high exactly in the 4th phase.
  - Status=0, XferCnt=4.
- **Master abort:** DevselN held high.
  - After 4 data clocks: ABORT, then TURN.
  - Done with Status=3, XferCnt=0, no RdValid/WrNext.
- **Retry:** StopN=0, TrdyN=1 at the first data phase of a Len=4 read.
  - Status=2, XferCnt=0.
- **Disconnect:** Len=4 write; StopN=0 with TrdyN=0 on the 2nd transfer.
  - Status=1, XferCnt=2.
- **Reset mid-burst:** rst_n low during DATA.
  - All outputs reach reset values without a clock edge.
  - Req after reset release starts a fresh ADDR cycle.
